// File: rtl/mem_stage_pipelined.sv
// MEM stage: byte-addressed data RAM with sub-word load/store, configurable access latency,
// misalignment detection and registered MEM/WB outputs.
module mem_stage_pipelined #(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ACCESS_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        rw,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic        mux_sel,
  input  logic [31:0] addr_in,
  input  logic [31:0] data_in,
  output logic        stall,
  output logic        valid_out,
  output logic [31:0] data_out,
  output logic [31:0] addr_out,
  output logic [31:0] wb_out,
  output logic        misalign
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(ACCESS_LAT + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(ACCESS_LAT - 1);

  typedef enum logic {S_IDLE, S_WAIT} stateT;

  stateT           state, stateNext;
  logic [CntW-1:0] cnt, cntNext;

  logic        rwQ, signExtQ, muxSelQ;
  logic [1:0]  sizeQ;
  logic [31:0] addrQ, dataQ;

  logic [31:0] mem [DEPTH];

  logic        opRw, opSignExt, opMuxSel;
  logic [1:0]  opSize;
  logic [31:0] opAddr, opData;
  logic [IdxW-1:0] opIdx;
  logic        accept, done, misalignC;
  logic [31:0] rdWord, wrWord, loadData, dataNext;
  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  // Live inputs drive the access in IDLE; latched fields drive it from WAIT.
  always_comb begin
    opRw      = rw;
    opSize    = size;
    opSignExt = sign_ext;
    opMuxSel  = mux_sel;
    opAddr    = addr_in;
    opData    = data_in;
    if (state == S_WAIT) begin
      opRw      = rwQ;
      opSize    = sizeQ;
      opSignExt = signExtQ;
      opMuxSel  = muxSelQ;
      opAddr    = addrQ;
      opData    = dataQ;
    end
  end

  assign opIdx  = opAddr[IdxW+1:2];
  assign rdWord = mem[opIdx];
  assign accept = (state == S_IDLE) && en;

  always_comb begin
    misalignC = 1'b0;
    case (opSize)
      2'b00:   misalignC = 1'b0;
      2'b01:   misalignC = opAddr[0];
      default: misalignC = |opAddr[1:0];
    endcase
  end

  // Misaligned ops never wait; aligned ops wait unless the latency is a single edge.
  assign done = (accept && ((ACCESS_LAT == 1) || misalignC)) ||
                ((state == S_WAIT) && (cnt == CntW'(1)));

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    stall     = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept && !done) begin
          stateNext = S_WAIT;
          cntNext   = CntInit;
          stall     = 1'b1;
        end
      end
      S_WAIT: begin
        cntNext = cnt - CntW'(1);
        if (cnt == CntW'(1)) stateNext = S_IDLE;
        else                 stall     = 1'b1;
      end
      default: stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rwQ      <= 1'b0;
      sizeQ    <= 2'b00;
      signExtQ <= 1'b0;
      muxSelQ  <= 1'b0;
      addrQ    <= '0;
      dataQ    <= '0;
    end else if (accept) begin
      rwQ      <= rw;
      sizeQ    <= size;
      signExtQ <= sign_ext;
      muxSelQ  <= mux_sel;
      addrQ    <= addr_in;
      dataQ    <= data_in;
    end
  end

  // Little-endian lane extraction and store merge.
  always_comb begin
    byteLane = rdWord[{opAddr[1:0], 3'b000} +: 8];
    halfLane = rdWord[{opAddr[1], 4'b0000} +: 16];
    wrWord   = rdWord;
    loadData = rdWord;
    case (opSize)
      2'b00: begin
        loadData = {{24{opSignExt & byteLane[7]}}, byteLane};
        wrWord[{opAddr[1:0], 3'b000} +: 8] = opData[7:0];
      end
      2'b01: begin
        loadData = {{16{opSignExt & halfLane[15]}}, halfLane};
        wrWord[{opAddr[1], 4'b0000} +: 16] = opData[15:0];
      end
      default: wrWord = opData;
    endcase
    dataNext = (opRw || misalignC) ? 32'h0 : loadData;
  end

  always_ff @(posedge clk) begin
    if (!reset && done && opRw && !misalignC) mem[opIdx] <= wrWord;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      addr_out  <= '0;
      wb_out    <= '0;
      misalign  <= 1'b0;
    end else if (done) begin
      valid_out <= 1'b1;
      data_out  <= dataNext;
      addr_out  <= opAddr;
      wb_out    <= (opMuxSel && !opRw) ? dataNext : opAddr;
      misalign  <= misalignC;
    end else begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_pipelined.sv
// Directed bench for mem_stage_pipelined: three instances with ACCESS_LAT 1, 3 and 4.
module tb_mem_stage_pipelined;

  logic        clk;
  logic        reset    [3];
  logic        en       [3];
  logic        rw       [3];
  logic [1:0]  size     [3];
  logic        signExt  [3];
  logic        muxSel   [3];
  logic [31:0] addrIn   [3];
  logic [31:0] dataIn   [3];
  logic        stall    [3];
  logic        valid    [3];
  logic [31:0] dOut     [3];
  logic [31:0] aOut     [3];
  logic [31:0] wbOut    [3];
  logic        misal    [3];

  int nCmp = 0;
  int nErr = 0;

  mem_stage_pipelined #(.DEPTH(256), .ACCESS_LAT(1)) dut0 (
    .clk(clk), .reset(reset[0]), .en(en[0]), .rw(rw[0]), .size(size[0]),
    .sign_ext(signExt[0]), .mux_sel(muxSel[0]), .addr_in(addrIn[0]), .data_in(dataIn[0]),
    .stall(stall[0]), .valid_out(valid[0]), .data_out(dOut[0]), .addr_out(aOut[0]),
    .wb_out(wbOut[0]), .misalign(misal[0]));

  mem_stage_pipelined #(.DEPTH(256), .ACCESS_LAT(3)) dut1 (
    .clk(clk), .reset(reset[1]), .en(en[1]), .rw(rw[1]), .size(size[1]),
    .sign_ext(signExt[1]), .mux_sel(muxSel[1]), .addr_in(addrIn[1]), .data_in(dataIn[1]),
    .stall(stall[1]), .valid_out(valid[1]), .data_out(dOut[1]), .addr_out(aOut[1]),
    .wb_out(wbOut[1]), .misalign(misal[1]));

  mem_stage_pipelined #(.DEPTH(256), .ACCESS_LAT(4)) dut2 (
    .clk(clk), .reset(reset[2]), .en(en[2]), .rw(rw[2]), .size(size[2]),
    .sign_ext(signExt[2]), .mux_sel(muxSel[2]), .addr_in(addrIn[2]), .data_in(dataIn[2]),
    .stall(stall[2]), .valid_out(valid[2]), .data_out(dOut[2]), .addr_out(aOut[2]),
    .wb_out(wbOut[2]), .misalign(misal[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    if (obs !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One op on instance i; returns edges-to-valid (0 on timeout) and whether stall was seen.
  task automatic runOp(input int i, input logic rwV, input logic [1:0] sz, input logic sx,
                       input logic mx, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic stallSeen);
    @(negedge clk);
    rw[i] = rwV; size[i] = sz; signExt[i] = sx; muxSel[i] = mx;
    addrIn[i] = a; dataIn[i] = d; en[i] = 1'b1;
    #1 stallSeen = stall[i];
    @(negedge clk);
    en[i] = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      if (valid[i]) begin
        lat = n;
        break;
      end
      stallSeen = stallSeen | stall[i];
      @(negedge clk);
    end
  endtask

  initial begin
    int lat;
    logic st;
    int vCnt;

    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    logic st;
    int vCnt;

    for (int i = 0; i < 3; i++) begin
      reset[i] = 1'b1; en[i] = 1'b0; rw[i] = 1'b0; size[i] = 2'b00; signExt[i] = 1'b0;
      muxSel[i] = 1'b0; addrIn[i] = '0; dataIn[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) reset[i] = 1'b0;
    @(negedge clk);
    checkVal("rst valid", 32'(valid[0]), 32'h0);
    checkVal("rst data", dOut[0], 32'h0);
    checkVal("rst wb", wbOut[0], 32'h0);
    checkVal("rst misal", 32'(misal[0]), 32'h0);
    checkVal("rst stall", 32'(stall[1]), 32'h0);

    // Word store/load at single-edge latency
    runOp(0, 1'b1, 2'b10, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, st);
    checkVal("t1 st lat", 32'(lat), 32'd1);
    checkVal("t1 st stall", 32'(st), 32'h0);
    checkVal("t1 st wb", wbOut[0], 32'h10);
    checkVal("t1 st data", dOut[0], 32'h0);
    runOp(0, 1'b0, 2'b10, 1'b0, 1'b1, 32'h10, 32'h0, lat, st);
    checkVal("t1 ld lat", 32'(lat), 32'd1);
    checkVal("t1 ld stall", 32'(st), 32'h0);
    checkVal("t1 ld data", dOut[0], 32'hDEADBEEF);
    checkVal("t1 ld wb", wbOut[0], 32'hDEADBEEF);
    @(negedge clk);
    checkVal("t1 pulse", 32'(valid[0]), 32'h0);

    // Sub-word lanes and extension
    runOp(0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h20, 32'h11223344, lat, st);
    runOp(0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h21, 32'hAAAAAA80, lat, st);
    runOp(0, 1'b0, 2'b00, 1'b1, 1'b1, 32'h21, 32'h0, lat, st);
    checkVal("t2 lb s", dOut[0], 32'hFFFFFF80);
    runOp(0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h21, 32'h0, lat, st);
    checkVal("t2 lb u", dOut[0], 32'h00000080);
    runOp(0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h22, 32'h55558001, lat, st);
    runOp(0, 1'b0, 2'b01, 1'b1, 1'b1, 32'h22, 32'h0, lat, st);
    checkVal("t2 lh s", dOut[0], 32'hFFFF8001);
    runOp(0, 1'b0, 2'b11, 1'b0, 1'b1, 32'h20, 32'h0, lat, st);
    checkVal("t2 lw", dOut[0], 32'h80018044);

    // Multi-cycle latency with inputs toggled during WAIT
    runOp(1, 1'b1, 2'b10, 1'b0, 1'b1, 32'h30, 32'hCAFEF00D, lat, st);
    checkVal("t3 st lat", 32'(lat), 32'd3);
    checkVal("t3 st stall", 32'(st), 32'h1);
    @(negedge clk);
    rw[1] = 1'b0; size[1] = 2'b10; signExt[1] = 1'b0; muxSel[1] = 1'b1;
    addrIn[1] = 32'h30; en[1] = 1'b1;
    #1 checkVal("t3 acc stall", 32'(stall[1]), 32'h1);
    @(negedge clk);
    checkVal("t3 w1 stall", 32'(stall[1]), 32'h1);
    checkVal("t3 w1 valid", 32'(valid[1]), 32'h0);
    rw[1] = 1'b1; size[1] = 2'b00; addrIn[1] = 32'h31; dataIn[1] = 32'h0; muxSel[1] = 1'b0;
    @(negedge clk);
    checkVal("t3 w2 stall", 32'(stall[1]), 32'h0);
    checkVal("t3 w2 valid", 32'(valid[1]), 32'h0);
    addrIn[1] = 32'h34;
    @(negedge clk);
    en[1] = 1'b0;
    checkVal("t3 valid", 32'(valid[1]), 32'h1);
    checkVal("t3 data", dOut[1], 32'hCAFEF00D);
    checkVal("t3 addr", aOut[1], 32'h30);
    checkVal("t3 wb", wbOut[1], 32'hCAFEF00D);
    runOp(1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h30, 32'h0, lat, st);
    checkVal("t3 rb", dOut[1], 32'hCAFEF00D);

    // Misaligned accesses complete immediately
    runOp(0, 1'b0, 2'b10, 1'b0, 1'b1, 32'h12, 32'h0, lat, st);
    checkVal("t4 ld lat", 32'(lat), 32'd1);
    checkVal("t4 ld misal", 32'(misal[0]), 32'h1);
    checkVal("t4 ld data", dOut[0], 32'h0);
    runOp(0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h12, 32'hFFFFFFFF, lat, st);
    checkVal("t4 st misal", 32'(misal[0]), 32'h1);
    runOp(0, 1'b0, 2'b10, 1'b0, 1'b1, 32'h10, 32'h0, lat, st);
    checkVal("t4 rb", dOut[0], 32'hDEADBEEF);
    checkVal("t4 rb misal", 32'(misal[0]), 32'h0);
    runOp(1, 1'b0, 2'b01, 1'b0, 1'b1, 32'h31, 32'h0, lat, st);
    checkVal("t4 l3 lat", 32'(lat), 32'd1);
    checkVal("t4 l3 stall", 32'(st), 32'h0);
    checkVal("t4 l3 misal", 32'(misal[1]), 32'h1);

    // Reset during WAIT aborts the store
    runOp(2, 1'b1, 2'b10, 1'b0, 1'b0, 32'h40, 32'hA5A5A5A5, lat, st);
    checkVal("t5 st lat", 32'(lat), 32'd4);
    @(negedge clk);
    rw[2] = 1'b1; size[2] = 2'b10; addrIn[2] = 32'h40; dataIn[2] = 32'h12345678; en[2] = 1'b1;
    @(negedge clk);
    en[2] = 1'b0; reset[2] = 1'b1;
    @(negedge clk);
    reset[2] = 1'b0;
    checkVal("t5 stall", 32'(stall[2]), 32'h0);
    checkVal("t5 addr", aOut[2], 32'h0);
    checkVal("t5 wb", wbOut[2], 32'h0);
    vCnt = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (valid[2]) vCnt++;
    end
    checkVal("t5 novalid", 32'(vCnt), 32'd0);
    runOp(2, 1'b0, 2'b10, 1'b0, 1'b1, 32'h40, 32'h0, lat, st);
    checkVal("t5 rb", dOut[2], 32'hA5A5A5A5);

    // Address write-back select and index wrap
    runOp(0, 1'b0, 2'b10, 1'b0, 1'b0, 32'h08, 32'h0, lat, st);
    checkVal("t6 wb addr", wbOut[0], 32'h00000008);
    runOp(0, 1'b1, 2'b10, 1'b0, 1'b1, 32'h400, 32'h0BADF00D, lat, st);
    checkVal("t6 st wb", wbOut[0], 32'h400);
    runOp(0, 1'b0, 2'b10, 1'b0, 1'b1, 32'h000, 32'h0, lat, st);
    checkVal("t6 wrap", dOut[0], 32'h0BADF00D);
    checkVal("t6 addr", aOut[0], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
